pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Stall/flush sequencer for the 5-stage pipeline. It works alongside the operand forwarding unit and covers the hazards forwarding cannot resolve: load-use dependencies, taken branches resolved in EX, and multi-cycle data-memory accesses.
- Drives the write-enable and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating performance counters.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; synchronous, active-low.
- ID_EX_memRead  in  1  instruction in EX is a load.
- ID_EX_rt  in  5  load destination register.
- IF_ID_rs  in  5  source register rs of the instruction in ID.
- IF_ID_rt  in  5  source register rt of the instruction in ID.
- IF_ID_usesRt  in  1  ID instruction reads rt as a source.
- EX_branchTaken  in  1  branch in EX resolved taken.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  clear IF/ID to NOP.
- ID_EX_write  out  1  ID/EX load enable.
- ID_EX_bubble  out  1  load NOP into ID/EX.
- EX_MEM_write  out  1  EX/MEM load enable.
- MEM_WB_bubble  out  1  load NOP into MEM/WB.
- stall_count  out  CNT_W  cycles with PC_write=0.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:
- Timing: state and counters are registered; control outputs are combinational from state and current inputs (zero latency).
- States:
  - RUN: normal issue.
  - LOAD_STALL: load-use bubbles in progress; 3-bit down-counter `remain`.
  - MEM_WAIT: whole pipeline frozen; `resume` register holds RUN or LOAD_STALL.
- Reset (rst_n=0 at a clk edge):
  - state=RUN, remain=0, resume=RUN, both counters 0.
  - Outputs while rst_n=0: all *_write=0, all flush/bubble=1.
  - Reset mid-stall aborts the stall; no state is retained.
- Default outputs: *_write=1, flush/bubble=0.
- Priority each cycle: mem-wait, then branch, then load-use.
- Mem-wait (condition: mem_req=1 and mem_ready=0, any state):
  - PC_write, IF_ID_write, ID_EX_write, EX_MEM_write all 0; MEM_WB_bubble=1.
  - On entry, resume = current state (LOAD_STALL if entered from it); remain is frozen.
  - Stay in MEM_WAIT while mem_ready=0.
  - In the cycle mem_ready=1: MEM_WAIT actions are dropped and the branch and load-use rules are evaluated as in `resume`; the next state follows from those rules.
- Branch (EX_branchTaken=1, not mem-waiting):
  - IF_ID_flush=1, ID_EX_bubble=1, PC_write=1.
  - Aborts any LOAD_STALL: remain=0, next state RUN.
  - flush_count += 1.
- Load-use hazard, detected in RUN only:
  - Condition: ID_EX_memRead && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || (IF_ID_usesRt && ID_EX_rt==IF_ID_rt)).
  - That cycle: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
  - If LOAD_STALL_CYCLES>1: remain=LOAD_STALL_CYCLES-1 and go to LOAD_STALL; otherwise stay in RUN.
- LOAD_STALL:
  - Same outputs as the detection cycle (PC_write=0, IF_ID_write=0, ID_EX_bubble=1); remain decrements.
  - When remain==1 in this cycle, next state is RUN.
  - No new hazard detection occurs in this state.
- Register 0 never triggers a hazard.
- stall_count += 1 in every non-reset cycle with PC_write=0.
- Both counters saturate at all-ones; they never wrap.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State enum: RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2.
  - REG_ZERO=5'd0.
  - Register-index width of 5.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count). It is instantiated twice, once per counter.

Test Plan:
- Load-use: ID_EX_memRead=1, ID_EX_rt=5, IF_ID_rs=5, LOAD_STALL_CYCLES=1 -> one cycle of PC_write=0 and ID_EX_bubble=1, then RUN; stall_count=1.
- Zero register: same stimulus with ID_EX_rt=0, or rt match with IF_ID_usesRt=0 -> no stall; all *_write=1.
- Multi-bubble: LOAD_STALL_CYCLES=3, hazard -> exactly 3 cycles with ID_EX_bubble=1; branch asserted on the 2nd cycle -> IF_ID_flush=1 that cycle, next state RUN, flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> 4 frozen cycles with MEM_WB_bubble=1 and EX_MEM_write=0, then normal; stall_count=4.
- Mem-wait inside LOAD_STALL: remain=2 when mem_ready drops for 2 cycles -> after ready, exactly 2 further bubbles, then RUN.
- Reset and saturation: rst_n=0 in MEM_WAIT -> next cycle state RUN, counters 0. With CNT_W=4, hold 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// State encoding, register-index width and the load-use hazard check.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2
    } pipe_state_e;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and memory-wait freezes, plus saturating stall/flush counters.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_memRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_usesRt,
    input  logic             EX_branchTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] StallInit = 3'(LOAD_STALL_CYCLES - 1);

    pipe_state_e state_d, state_q;
    pipe_state_e resume_d, resume_q;
    pipe_state_e eff_state;
    logic [2:0]  remain_d, remain_q;
    logic        hazard;
    logic        stall_inc;
    logic        flush_inc;

    assign hazard = load_use_hazard(ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_usesRt);

    // Once memory is ready, rules are evaluated as if the freeze never happened.
    assign eff_state = (state_q == StMemWait) ? resume_q : state_q;

    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        state_d       = state_q;
        resume_d      = resume_q;
        remain_d      = remain_q;
        flush_inc     = 1'b0;

        if (!rst_n) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_write   = 1'b0;
            ID_EX_bubble  = 1'b1;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (mem_req && !mem_ready) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
            state_d       = StMemWait;
            if (state_q != StMemWait) begin
                resume_d = state_q;
            end
        end else if (EX_branchTaken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            remain_d     = 3'd0;
            state_d      = StRun;
            flush_inc    = 1'b1;
        end else if (eff_state == StLoadStall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            remain_d     = remain_q - 3'd1;
            state_d      = (remain_q == 3'd1) ? StRun : StLoadStall;
        end else if (hazard) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                remain_d = StallInit;
                state_d  = StLoadStall;
            end else begin
                state_d = StRun;
            end
        end else begin
            state_d = StRun;
        end
    end

    assign stall_inc = rst_n && !PC_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            resume_q <= StRun;
            remain_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            remain_q <= remain_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (stall_inc),
        .count(stall_count)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush_inc),
        .count(flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed table, multi-cycle sequences and
// random stimulus checked against a bubble-owed reference model on three configurations.
module tb_pipeline_hazard_controller;

    localparam int N = 3;
    // Control bundle order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
    //                        ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    localparam logic [6:0] RST = 7'b0010101;
    localparam logic [6:0] NRM = 7'b1101010;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] BRN = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, mr, ut, br, mq, my;
    logic [4:0] ex_rt, rs, rt;

    logic [6:0]  ctl_a, ctl_b, ctl_c;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ID_EX_memRead(mr), .ID_EX_rt(ex_rt), .IF_ID_rs(rs),
        .IF_ID_rt(rt), .IF_ID_usesRt(ut), .EX_branchTaken(br), .mem_req(mq), .mem_ready(my),
        .PC_write(ctl_a[6]), .IF_ID_write(ctl_a[5]), .IF_ID_flush(ctl_a[4]),
        .ID_EX_write(ctl_a[3]), .ID_EX_bubble(ctl_a[2]), .EX_MEM_write(ctl_a[1]),
        .MEM_WB_bubble(ctl_a[0]), .stall_count(sc_a), .flush_count(fc_a)
    );

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ID_EX_memRead(mr), .ID_EX_rt(ex_rt), .IF_ID_rs(rs),
        .IF_ID_rt(rt), .IF_ID_usesRt(ut), .EX_branchTaken(br), .mem_req(mq), .mem_ready(my),
        .PC_write(ctl_b[6]), .IF_ID_write(ctl_b[5]), .IF_ID_flush(ctl_b[4]),
        .ID_EX_write(ctl_b[3]), .ID_EX_bubble(ctl_b[2]), .EX_MEM_write(ctl_b[1]),
        .MEM_WB_bubble(ctl_b[0]), .stall_count(sc_b), .flush_count(fc_b)
    );

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .ID_EX_memRead(mr), .ID_EX_rt(ex_rt), .IF_ID_rs(rs),
        .IF_ID_rt(rt), .IF_ID_usesRt(ut), .EX_branchTaken(br), .mem_req(mq), .mem_ready(my),
        .PC_write(ctl_c[6]), .IF_ID_write(ctl_c[5]), .IF_ID_flush(ctl_c[4]),
        .ID_EX_write(ctl_c[3]), .ID_EX_bubble(ctl_c[2]), .EX_MEM_write(ctl_c[1]),
        .MEM_WB_bubble(ctl_c[0]), .stall_count(sc_c), .flush_count(fc_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bubbles still owed, plus plain integer counters.
    int owed[N];
    int m_sc[N];
    int m_fc[N];
    int lsc[N]  = '{1, 3, 3};
    int cmax[N] = '{65535, 65535, 15};

    typedef struct {
        logic       r, m;
        logic [4:0] e, s, t;
        logic       u, b, q, y;
        logic [6:0] ctl;
        int         sc, fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, m, input logic [4:0] e, s, t,
                                input logic u, b, q, y, input logic [6:0] ctl,
                                input int sc, fc);
        vec_t v;
        v.r = r; v.m = m; v.e = e; v.s = s; v.t = t; v.u = u; v.b = b; v.q = q; v.y = y;
        v.ctl = ctl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, m, input logic [4:0] e, s, t,
                         input logic u, b, q, y);
        rst_n = r; mr = m; ex_rt = e; rs = s; rt = t; ut = u; br = b; mq = q; my = y;
    endtask

    function automatic logic [6:0] model_ctl(input int k);
        if (!rst_n) return RST;
        if (mq && !my) return FRZ;
        if (br) return BRN;
        if (owed[k] > 0) return STL;
        if (mr && ex_rt != 0 && (ex_rt == rs || (ut && ex_rt == rt))) return STL;
        return NRM;
    endfunction

    task automatic model_update(input int k, input logic [6:0] ctl);
        if (!rst_n) begin
            owed[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            return;
        end
        if (!(mq && !my)) begin
            if (br) begin
                owed[k] = 0;
                if (m_fc[k] < cmax[k]) m_fc[k]++;
            end else if (owed[k] > 0) begin
                owed[k]--;
            end else if (ctl == STL) begin
                owed[k] = lsc[k] - 1;
            end
        end
        if (!ctl[6] && m_sc[k] < cmax[k]) m_sc[k]++;
    endtask

    // Sample on the falling edge, compare every instance against the model.
    task automatic settle();
        logic [6:0]  act;
        logic [31:0] asc, afc;
        logic [6:0]  exp;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            case (k)
                0:       begin act = ctl_a; asc = 32'(sc_a); afc = 32'(fc_a); end
                1:       begin act = ctl_b; asc = 32'(sc_b); afc = 32'(fc_b); end
                default: begin act = ctl_c; asc = 32'(sc_c); afc = 32'(fc_c); end
            endcase
            exp = model_ctl(k);
            check($sformatf("model dut%0d ctl", k), 32'(act), 32'(exp));
            check($sformatf("model dut%0d stall_count", k), asc, 32'(m_sc[k]));
            check($sformatf("model dut%0d flush_count", k), afc, 32'(m_fc[k]));
            model_update(k, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string nm, input logic [6:0] exp);
        settle();
        check(nm, 32'(ctl_b), 32'(exp));
        adv();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        adv();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0));
        tbl.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 0, STL, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 0));
        tbl.push_back(mk(1, 1, 7, 3, 7, 0, 0, 0, 0, NRM, 1, 0));
        tbl.push_back(mk(1, 1, 7, 3, 7, 1, 0, 0, 0, STL, 1, 0));
        tbl.push_back(mk(1, 1, 7, 7, 7, 1, 1, 0, 0, BRN, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 4, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].m, tbl[i].e, tbl[i].s, tbl[i].t,
                  tbl[i].u, tbl[i].b, tbl[i].q, tbl[i].y);
            settle();
            check($sformatf("vec%0d ctl", i), 32'(ctl_a), 32'(tbl[i].ctl));
            check($sformatf("vec%0d stall_count", i), 32'(sc_a), 32'(tbl[i].sc));
            check($sformatf("vec%0d flush_count", i), 32'(fc_a), 32'(tbl[i].fc));
            adv();
        end

        // Three bubbles per hazard with LOAD_STALL_CYCLES=3.
        do_reset();
        drive(1, 1, 5, 5, 0, 0, 0, 0, 0); step_b("multi bubble 1", STL);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step_b("multi bubble 2", STL);
        step_b("multi bubble 3", STL);
        settle();
        check("multi bubble done", 32'(ctl_b), 32'(NRM));
        check("multi bubble stall_count", 32'(sc_b), 32'd3);
        adv();

        // Branch on the second bubble aborts the stall.
        do_reset();
        drive(1, 1, 5, 5, 0, 0, 0, 0, 0); step_b("abort bubble", STL);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step_b("abort branch", BRN);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("abort run", 32'(ctl_b), 32'(NRM));
        check("abort flush_count", 32'(fc_b), 32'd1);
        check("abort stall_count", 32'(sc_b), 32'd1);
        adv();

        // Memory wait while two bubbles are still owed.
        do_reset();
        drive(1, 1, 5, 5, 0, 0, 0, 0, 0); step_b("memstall detect", STL);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step_b("memstall frz1", FRZ);
        step_b("memstall frz2", FRZ);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1); step_b("memstall resume1", STL);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step_b("memstall resume2", STL);
        step_b("memstall run", NRM);

        // Reset while frozen.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step_b("rstwait frz1", FRZ);
        step_b("rstwait frz2", FRZ);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step_b("rstwait reset", RST);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("rstwait run", 32'(ctl_b), 32'(NRM));
        check("rstwait stall_count", 32'(sc_b), 32'd0);
        check("rstwait flush_count", 32'(fc_b), 32'd0);
        adv();

        // Saturation of the 4-bit counter.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) begin
            settle();
            adv();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("saturate 4-bit stall_count", 32'(sc_c), 32'd15);
        check("wide stall_count", 32'(sc_a), 32'd20);
        adv();

        do_reset();
        repeat (400) begin
            drive(($urandom % 50) != 0, 1'($urandom), 5'($urandom % 4), 5'($urandom % 4),
                  5'($urandom % 4), 1'($urandom), ($urandom % 8) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) != 0);
            settle();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
